// File: rtl/axi_slv_mem_if.sv
// rtl/axi_slv_mem_if.sv - AXI3 bus bundle between a master and the axi_slv_mem responder
interface axi_slv_mem_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awbrust;
   logic [1:0]          awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrob;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arbrust;
   logic [1:0]          arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awbrust, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrob, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arbrust, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awbrust, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrob, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arbrust, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_slv_mem.sv
// rtl/axi_slv_mem.sv - AXI3 slave with internal word-addressed memory, independent write/read FSMs
module axi_slv_mem #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input logic          aclk,
   input logic          arst,
   axi_slv_mem_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(DEPTH * STRB_W);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < MEM_LIMIT;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return a[LSB +: IDX_W];
   endfunction

   function automatic logic wrap_len_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

   // Errors known from the address phase alone: oversize beat, reserved burst, malformed WRAP
   function automatic logic burst_bad(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] step;
      step = ADDR_W'(1) << size;
      return (size > 3'(LSB)) || (burst == 2'b11) ||
             ((burst == 2'b10) && (!wrap_len_ok(len) || ((a & (step - ADDR_W'(1))) != '0)));
   endfunction

   // Address of the following beat; reserved and malformed WRAP bursts advance as INCR
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                                   input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] step, incr, span, base, nxt;
      step = ADDR_W'(1) << size;
      incr = (a & ~(step - ADDR_W'(1))) + step;
      span = ADDR_W'({1'b0, len} + 5'd1) << size;
      base = a & ~(span - ADDR_W'(1));
      nxt  = incr;
      if (burst == 2'b00) begin
         nxt = a;
      end else if ((burst == 2'b10) && wrap_len_ok(len) && (incr == base + span)) begin
         nxt = base;
      end
      return nxt;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic              live;
   w_state_t          w_state, w_next;
   r_state_t          r_state, r_next;

   logic              aw_ready, w_ready, b_valid, ar_ready, r_valid;
   logic [1:0]        b_resp;
   logic              aw_hs, w_hs, ar_hs, r_hs, r_step;

   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_len, w_cnt;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_err;
   logic              w_addr_ok, w_id_ok, w_last_ok, w_wen;

   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr, r_addr_nxt, beat_addr;
   logic [3:0]        r_len, r_cnt, beat_cnt, beat_len;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              r_err, beat_err;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_last;

   logic              unused_sideband;
   assign unused_sideband = ^{bus.awlock, bus.awcache, bus.awprot, bus.arlock, bus.arcache, bus.arprot};

   // Keep both address channels closed until the first edge after reset is released
   always_ff @(posedge aclk) begin
      if (arst) live <= 1'b0;
      else      live <= 1'b1;
   end

   // Write FSM state register
   always_ff @(posedge aclk) begin
      if (arst) w_state <= W_IDLE;
      else      w_state <= w_next;
   end

   // Write FSM next state and channel handshake outputs
   always_comb begin
      w_next   = w_state;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      b_resp   = 2'b00;
      case (w_state)
         W_IDLE: begin
            aw_ready = live;
            if (bus.awvalid && live) w_next = W_DATA;
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (bus.wvalid && (w_cnt == w_len)) w_next = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            b_resp  = w_err ? 2'b10 : 2'b00;
            if (bus.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign aw_hs     = bus.awvalid & aw_ready;
   assign w_hs      = bus.wvalid & w_ready;
   assign w_addr_ok = in_range(w_addr);
   assign w_id_ok   = (bus.wid == w_id);
   assign w_last_ok = (bus.wlast == (w_cnt == w_len));
   assign w_wen     = w_hs & w_addr_ok & w_id_ok & ~arst;

   // Write burst context: latched on AW, stepped per accepted W beat, errors accumulate into bresp
   always_ff @(posedge aclk) begin
      if (arst) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         w_id    <= bus.awid;
         w_addr  <= bus.awaddr;
         w_len   <= bus.awlen;
         w_size  <= bus.awsize;
         w_burst <= bus.awbrust;
         w_cnt   <= '0;
         w_err   <= burst_bad(bus.awaddr, bus.awlen, bus.awsize, bus.awbrust);
      end else if (w_hs) begin
         w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
         w_cnt   <= w_cnt + 4'd1;
         w_err   <= w_err | ~(w_addr_ok & w_id_ok & w_last_ok);
      end
   end

   // Byte-lane memory write; no reset so contents survive arst
   always_ff @(posedge aclk) begin
      if (w_wen) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrob[b]) mem[word_idx(w_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge aclk) begin
      if (arst) r_state <= R_IDLE;
      else      r_state <= r_next;
   end

   // Read FSM next state and channel handshake outputs
   always_comb begin
      r_next   = r_state;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            ar_ready = live;
            if (bus.arvalid && live) r_next = R_DATA;
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (bus.rready && r_last) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign ar_hs      = bus.arvalid & ar_ready;
   assign r_hs       = bus.rready & r_valid;
   assign r_step     = r_hs & ~r_last;
   assign r_addr_nxt = next_addr(r_addr, r_len, r_size, r_burst);
   assign beat_addr  = ar_hs ? bus.araddr : r_addr_nxt;
   assign beat_cnt   = ar_hs ? 4'd0 : r_cnt + 4'd1;
   assign beat_len   = ar_hs ? bus.arlen : r_len;
   assign beat_err   = ar_hs ? burst_bad(bus.araddr, bus.arlen, bus.arsize, bus.arbrust) : r_err;

   // Read beat register: loaded on AR and after each non-final R handshake, held while stalled
   always_ff @(posedge aclk) begin
      if (arst) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_resp  <= 2'b00;
         r_last  <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_id    <= bus.arid;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arbrust;
            r_err   <= beat_err;
         end
         if (ar_hs || r_step) begin
            r_addr <= beat_addr;
            r_cnt  <= beat_cnt;
            r_data <= in_range(beat_addr) ? mem[word_idx(beat_addr)] : '0;
            r_resp <= (beat_err || !in_range(beat_addr)) ? 2'b10 : 2'b00;
            r_last <= (beat_cnt == beat_len);
         end
      end
   end

   assign bus.awready = aw_ready;
   assign bus.wready  = w_ready;
   assign bus.bid     = w_id;
   assign bus.bresp   = b_resp;
   assign bus.bvalid  = b_valid;
   assign bus.arready = ar_ready;
   assign bus.rid     = r_id;
   assign bus.rdata   = r_data;
   assign bus.rresp   = r_resp;
   assign bus.rlast   = r_last;
   assign bus.rvalid  = r_valid;
endmodule

// File: doc/axi_slv_mem.md
Name: axi_slv_mem

Overview:
- AXI3 slave (responder) RTL with an internal word-addressed memory.
- Sits at the far end of the AXI3 interface that the master driver drives, so master-VIP sequences run against real RTL instead of monitor-driven responses.
- Write and read channels run as independent FSMs, each with one outstanding transaction.
- Supports FIXED, INCR and WRAP bursts, byte strobes, and OKAY/SLVERR responses.

Parameters:
- ID_W, 4, width of awid/wid/bid/arid/rid
- ADDR_W, 32, byte address width
- DATA_W, 32, data width in bits; strobe width is DATA_W/8
- DEPTH, 1024, memory depth in DATA_W words; byte range 0 .. DEPTH*DATA_W/8-1

Ports:
- aclk  in  1  clock, all logic on rising edge
- arst  in  1  reset, synchronous, active-high
- awid  in  ID_W  write address ID
- awaddr  in  ADDR_W  write start address
- awlen  in  4  beats-1
- awsize  in  3  bytes/beat = 2^awsize
- awbrust  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awlock  in  2  accepted, ignored
- awcache  in  4  accepted, ignored
- awprot  in  3  accepted, ignored
- awvalid  in  1  / awready  out  1  AW handshake
- wid  in  ID_W  write data ID
- wdata  in  DATA_W  write data
- wstrob  in  DATA_W/8  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  / wready  out  1  W handshake
- bid  out  ID_W  / bresp  out  2  / bvalid  out  1  / bready  in  1  B channel
- arid  in  ID_W  / araddr  in  ADDR_W  / arlen  in  4  / arsize  in  3  / arbrust  in  2  read address fields
- arlock  in  2  / arcache  in  4  / arprot  in  3  accepted, ignored
- arvalid  in  1  / arready  out  1  AR handshake
- rid  out  ID_W  / rdata  out  DATA_W  / rresp  out  2  / rlast  out  1  / rvalid  out  1  / rready  in  1  R channel

Behaviour:
- Reset (arst high at a clock edge):
  - All outputs are 0.
  - Both FSMs go to IDLE and error flags clear, including when a burst is in progress.
  - Memory contents are not cleared.
  - awready and arready rise on the first edge after arst deasserts.
- Handshake: a transfer occurs on a clock edge where valid&ready=1. The slave never drops bvalid or rvalid before the handshake, and holds bid/bresp and rid/rdata/rresp/rlast stable meanwhile.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst and clear err; go to W_DATA with awready=0 and wready=1.
  - W_DATA: on each W handshake, write the bytes where wstrob=1 into mem[addr/(DATA_W/8)], advance addr, increment the beat counter. On the beat where counter==len, go to W_RESP with wready=0 and bvalid=1.
  - W_RESP: bid = latched id. bresp=2'b10 if err, else 2'b00. On B handshake go to W_IDLE; awready=1 the next cycle.
  - Minimum write cost: 1 AW cycle + (len+1) beats + 1 B cycle; a new AW is not accepted until the cycle after the B handshake.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the read fields; rvalid=1 on the next edge.
  - R_DATA: rdata = mem[addr word]. rlast=1 when counter==len. rresp = 2'b10 for an erroring beat, else 2'b00.
  - On each R handshake, advance addr. If not last, the next beat is presented the following cycle (one beat per cycle under continuous rready). After the last beat go to R_IDLE.
- Address advance:
  - FIXED: addr unchanged.
  - INCR: addr = (addr aligned to 2^size) + 2^size.
  - WRAP: wrap span = (len+1)*2^size. Next addr wraps to the span-aligned base when it reaches base+span.
- Error conditions; each sets err (write) or flags the beat SLVERR (read):
  - size > log2(DATA_W/8).
  - Burst 2'b11; address is advanced as INCR.
  - WRAP with len not in {1,3,7,15}, or a start address not aligned to 2^size.
  - Beat address out of range: write beat dropped, read beat returns rdata=0.
  - wid != latched awid: beat not written.
  - wlast mismatch (wlast=1 before the final beat, or 0 on it): the burst length is still taken from awlen.
- Simultaneous write and read to the same word in one cycle: the read returns the old data, and the write completes.
- No cross-channel ordering; the write and read FSMs never stall each other.

Test Plan:
- Reset mid-burst: assert arst during beat 2 of a 4-beat write -> next cycle bvalid=0, wready=0, awready=0. The first edge after release gives awready=1, and the words already written persist.
- INCR write then read, 32-bit: awaddr=0x10, awlen=3, awsize=2, data A0..A3, wstrob=4'hF -> bresp=00. Read back araddr=0x10, arlen=3 -> rdata A0..A3, rlast only on beat 3, rresp=00, rid=arid.
- WRAP: write 0x0..0xF to addresses 0x0..0xC, then araddr=0x08, arlen=3, arsize=2, arbrust=10 -> word addresses 0x08, 0x0C, 0x00, 0x04.
- Strobe plus backpressure: write 0xAABBCCDD to 0x40 with wstrob=4'b0101 over the old value 0x11223344 -> reads back 0x11BB33DD. Holding rready=0 for 3 cycles keeps rvalid, rdata and rlast stable.
- Errors: awsize=3 -> bresp=10. araddr=DEPTH*4 -> rresp=10, rdata=0. A wid mismatch on beat 1 -> bresp=10 and that word is unchanged.
